// File: rtl/nco_pkg.sv
// Shared types, constants and elaboration-time helpers for the programmable IQ NCO.
// Holds the quarter-wave table generator, quadrant codes, LFSR constants and a tuning-word helper.
package nco_pkg;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quad_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16+x^14+x^13+x^11+1 in right-shift Fibonacci form taps bits 0, 2, 3 and 5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  localparam real PI = 3.14159265358979323846;

  // Entry j of the quarter-wave table; the half-bin offset keeps every entry below full scale.
  function automatic int quarter_entry(input int j, input int res, input int frac);
    real n;
    real x;
    n = real'(1 << (res - 2));
    x = (2.0 ** frac) * $cos((PI / 2.0) * (real'(j) + 0.5) / n);
    return $rtoi(x + 0.5);
  endfunction

  // Tuning word for a parent instantiating the NCO at a fixed output frequency.
  function automatic longint unsigned ftw_from_freq(input real freq, input real fs,
                                                    input int acc_w);
    real x;
    x = (freq / fs) * (2.0 ** acc_w);
    return longint'(x);
  endfunction

endpackage

// File: rtl/nco_iq_prog_if.sv
// Control and sample bus of the programmable IQ NCO.
// The parent drives through the master modport; the NCO core attaches to the slave modport.
interface nco_iq_prog_if #(
  parameter int ACC_W        = 24,
  parameter int RES          = 8,
  parameter int SYMBOL_WIDTH = 16
);
  logic                           en;
  logic                           new_sample;
  logic [ACC_W-1:0]               ftw_in;
  logic                           ftw_load;
  logic [RES-1:0]                 offset;
  logic                           sync_clr;
  logic signed [SYMBOL_WIDTH-1:0] I;
  logic signed [SYMBOL_WIDTH-1:0] Q;
  logic                           out_valid;

  modport master (
    output en, new_sample, ftw_in, ftw_load, offset, sync_clr,
    input  I, Q, out_valid
  );

  modport slave (
    input  en, new_sample, ftw_in, ftw_load, offset, sync_clr,
    output I, Q, out_valid
  );
endinterface

// File: rtl/nco_quarter_rom.sv
// Dual-read quarter-wave cosine ROM with registered outputs (pipeline stage 1).
// Reads T[k] and T[N-1-k] together; the mirrored address is simply ~k.
module nco_quarter_rom
  import nco_pkg::*;
#(
  parameter int RES          = 8,
  parameter int SYMBOL_WIDTH = 16,
  parameter int SYMBOL_FRAC  = 14
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic [RES-3:0]                 k,
  output logic signed [SYMBOL_WIDTH-1:0] t_k,
  output logic signed [SYMBOL_WIDTH-1:0] t_nk
);

  localparam int N = 1 << (RES - 2);

  logic signed [SYMBOL_WIDTH-1:0] rom [N];

  for (genvar j = 0; j < N; j++) begin : g_tab
    localparam logic signed [SYMBOL_WIDTH-1:0] TV =
      SYMBOL_WIDTH'(quarter_entry(j, RES, SYMBOL_FRAC));
    assign rom[j] = TV;
  end

  // NOTE: the table is constant and its read registers carry no reset; the pipeline valid bits qualify the data.
  always_ff @(posedge clk) begin
    if (en) begin
      t_k  <= rom[k];
      t_nk <= rom[~k];
    end
  end

endmodule

// File: rtl/nco_iq_prog.sv
// Runtime-programmable quadrature NCO: phase accumulator, quarter-wave ROM, quadrant mapper.
// Optional build macro NCO_DITHER_EN adds LFSR phase dither ahead of the RES-bit truncation.
module nco_iq_prog
  import nco_pkg::*;
#(
  parameter int               SYMBOL_WIDTH = 16,
  parameter int               SYMBOL_FRAC  = 14,
  parameter int               ACC_W        = 24,
  parameter int               RES          = 8,
  parameter logic [ACC_W-1:0] FTW_RESET    = 24'h2AAAAA
) (
  input logic          clk,
  input logic          rst,
  nco_iq_prog_if.slave bus
);

  logic [ACC_W-1:0]               acc;
  logic [ACC_W-1:0]               shadow;
  logic [ACC_W-1:0]               active_ftw;
  logic [ACC_W-1:0]               sel_ftw;
  logic [ACC_W-1:0]               phase_src;
  logic                           pending;
  logic                           accepted;
  logic [RES-1:0]                 p;

  logic                           s0_valid;
  quad_t                          s0_q;
  logic [RES-3:0]                 s0_k;
  logic                           s1_valid;
  quad_t                          s1_q;
  logic signed [SYMBOL_WIDTH-1:0] t_k;
  logic signed [SYMBOL_WIDTH-1:0] t_nk;
  logic signed [SYMBOL_WIDTH-1:0] i_next;
  logic signed [SYMBOL_WIDTH-1:0] q_next;
  logic signed [SYMBOL_WIDTH-1:0] i_q;
  logic signed [SYMBOL_WIDTH-1:0] q_q;
  logic                           out_valid_q;

  assign accepted = bus.en & bus.new_sample;
  // A pending shadow word takes effect on the very increment that consumes it.
  assign sel_ftw  = pending ? shadow : active_ftw;

`ifdef NCO_DITHER_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else if (accepted) begin
      lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
    end
  end

  assign phase_src = acc + {{RES{1'b0}}, lfsr[ACC_W-RES-1:0]};
`else
  assign phase_src = acc;
`endif

  assign p = phase_src[ACC_W-1 -: RES] + bus.offset;

  // NOTE: sequential state uses non-blocking '<=' so every flop updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      shadow     <= FTW_RESET;
      active_ftw <= FTW_RESET;
      pending    <= 1'b0;
    end else begin
      if (bus.ftw_load) begin
        shadow <= bus.ftw_in;
      end
      if (accepted && pending) begin
        active_ftw <= shadow;
      end
      if (bus.ftw_load) begin
        pending <= 1'b1;
      end else if (accepted) begin
        pending <= 1'b0;
      end
      if (bus.en) begin
        if (bus.sync_clr) begin
          acc <= '0;
        end else if (accepted) begin
          acc <= acc + sel_ftw;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid    <= 1'b0;
      s0_q        <= Q0;
      s0_k        <= '0;
      s1_valid    <= 1'b0;
      s1_q        <= Q0;
      out_valid_q <= 1'b0;
      i_q         <= '0;
      q_q         <= '0;
    end else if (bus.en) begin
      s0_valid <= accepted;
      if (accepted) begin
        s0_q <= quad_t'(p[RES-1 -: 2]);
        s0_k <= p[RES-3:0];
      end
      s1_valid    <= s0_valid;
      s1_q        <= s0_q;
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        i_q <= i_next;
        q_q <= q_next;
      end
    end
  end

  nco_quarter_rom #(
    .RES         (RES),
    .SYMBOL_WIDTH(SYMBOL_WIDTH),
    .SYMBOL_FRAC (SYMBOL_FRAC)
  ) u_rom (
    .clk (clk),
    .en  (bus.en),
    .k   (s0_k),
    .t_k (t_k),
    .t_nk(t_nk)
  );

  // NOTE: always_comb uses blocking '=' and assigns every output first, so no latch is inferred.
  always_comb begin
    i_next = t_k;
    q_next = t_nk;
    case (s1_q)
      Q0: begin
        i_next = t_k;
        q_next = t_nk;
      end
      Q1: begin
        i_next = -t_nk;
        q_next = t_k;
      end
      Q2: begin
        i_next = -t_k;
        q_next = -t_nk;
      end
      Q3: begin
        i_next = t_nk;
        q_next = -t_k;
      end
      default: begin
        i_next = t_k;
        q_next = t_nk;
      end
    endcase
  end

  assign bus.I         = i_q;
  assign bus.Q         = q_q;
  // The strobe is masked while frozen so a held sample is announced only once enabled again.
  assign bus.out_valid = out_valid_q & bus.en;

endmodule

// File: doc/nco_iq_prog.md
Name: nco_iq_prog

Overview:
- Runtime-programmable quadrature NCO, the next generation of the fixed-frequency IQ sinusoid generator.
- Generates I = cos(θ) and Q = sin(θ) from a wide phase accumulator, using a quarter-wave LUT.
- Adds run-time frequency programming with glitch-free update, a phase-coherent restart, output valid strobes and a parametrised accumulator width.
- Feeds the BPSK modulator/demodulator mixers; ticked by the sample-rate strobe.

Parameters:
- SYMBOL_WIDTH, 16: output word length, signed two's complement.
- SYMBOL_FRAC, 14: fractional bits; amplitude A = 2^SYMBOL_FRAC; must be ≤ SYMBOL_WIDTH-2.
- ACC_W, 24: phase accumulator width.
- RES, 8: phase bits used for LUT lookup; LUT depth N = 2^(RES-2); must be ≥ 3 and ≤ ACC_W.
- FTW_RESET, 24'h2AAAAA: active tuning word after reset (1 MHz at 6 MS/s).

Ports:
- clk  in  1: clock.
- rst  in  1: synchronous active-high reset.
- en  in  1: global enable; when low, all state holds.
- new_sample  in  1: sample strobe; one output sample per accepted strobe.
- ftw_in  in  ACC_W: frequency tuning word.
- ftw_load  in  1: latch ftw_in into the shadow register.
- offset  in  RES: phase offset, added at LUT resolution.
- sync_clr  in  1: zero the accumulator (phase-coherent restart).
- I  out  SYMBOL_WIDTH: signed cos.
- Q  out  SYMBOL_WIDTH: signed sin.
- out_valid  out  1: one-cycle strobe marking a new I/Q pair.

Behaviour:
- Reset (clk edge with rst=1):
  - acc=0, shadow=active_ftw=FTW_RESET, pending=0.
  - Pipeline valids=0, I=Q=0, out_valid=0.
  - rst overrides every other input.
- ftw_load=1 (independent of en): shadow<=ftw_in, pending<=1. A later load before use overwrites the shadow.
- Accepted sample = en & new_sample.
- Stage 0, on an accepted sample:
  - p = acc[ACC_W-1 -: RES] + offset, mod 2^RES.
  - Register q=p[RES-1:RES-2] and k=p[RES-3:0].
  - If pending: active_ftw<=shadow, pending<=0.
  - Increment acc (mod 2^ACC_W) using the newly selected ftw, i.e. the shadow if pending, otherwise active_ftw.
  - The sample's phase always uses the pre-increment acc.
- sync_clr=1 on an accepted sample:
  - acc<=0; no increment that cycle. The sample itself still uses the old acc.
  - sync_clr with no accepted sample: acc<=0 if en.
- Stage 1: read T[k] and T[N-1-k]; register them with q.
- LUT contents: T[j] = round(A·cos((π/2)·(j+0.5)/N)); the half-bin offset avoids the value A and any zero-index wrap.
- Stage 2 quadrant mapping:
  - q0: I=T[k], Q=T[N-1-k].
  - q1: I=-T[N-1-k], Q=T[k].
  - q2: I=-T[k], Q=-T[N-1-k].
  - q3: I=T[N-1-k], Q=-T[k].
  - Negation cannot overflow because |T| ≤ A < 2^(SYMBOL_WIDTH-1).
- Latency: accepted sample in cycle t → I/Q update and out_valid=1 in cycle t+3.
  - out_valid is high for exactly one cycle per accepted sample.
  - Back-to-back samples (strobe every cycle) are supported at full rate.
- en=0 freezes the whole pipeline, outputs and valid bits. out_valid is forced 0 while en=0 and resumes on re-enable with no lost or duplicated samples.
- Reset mid-pipeline discards all in-flight samples; no out_valid follows the reset.

Optional Feature:
- Macro NCO_DITHER_EN.
- Defined:
  - 16-bit Fibonacci LFSR, seed 16'hACE1, taps x^16+x^14+x^13+x^11+1.
  - Advances once per accepted sample; reset reloads the seed.
  - Its low (ACC_W-RES) bits are added to acc before truncation to RES bits (requires ACC_W-RES ≤ 16). This spreads truncation spurs.
- Undefined: plain truncation, no LFSR logic. Test vectors below assume it undefined.

Decomposition:
- Package nco_pkg:
  - Quarter-table generator function (real math, elaboration-time).
  - Quadrant encoding constants Q0..Q3.
  - LFSR seed and tap constants.
  - Helper computing a tuning word from (FREQUENCY, SAMPLE_RATE, ACC_W) for instantiating parents.
- Sub-module nco_quarter_rom:
  - Dual-read, registered-output quarter-wave ROM parametrised by RES, SYMBOL_WIDTH and SYMBOL_FRAC; forms stage 1.

Test Plan:
- Reset, then one new_sample with default parameters and FTW_RESET → 3 cycles later out_valid=1, I=16383, Q=201 (q0, k=0).
- offset=8'd64, acc=0, one sample → I=-201, Q=16383. offset=8'd128 → I=-16383, Q=-201.
- FTW=2^22 (RES bits advance 64 per sample), continuous strobe → I sequence 16383, -201, -16383, 201 repeating, out_valid every cycle.
- ftw_load with 24'h100000 mid-stream → next accepted sample uses old phase; increments from it onward are 24'h100000; shadow rewritten twice before use → only the last value is applied.
- sync_clr with a sample after 10 steps → that output still reflects the old acc; next sample outputs I=16383, Q=201 (phase 0 again).
- en dropped for 5 cycles with 2 samples in flight → outputs frozen, no out_valid; on re-enable, both samples emerge in order. rst asserted with samples in flight → no out_valid, outputs 0.
